// File: rtl/alu_cmd_framer_if.sv
// alu_cmd_framer_if: UART rx/tx and ALU handshake bundle seen by the command framer.
// master is the framer side, slave is the surrounding UART/ALU side.
interface alu_cmd_framer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_start;
  logic [7:0] alu_result;
  logic       alu_done;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic       frame_err;
  modport master (
    input  rx_data, rx_valid, alu_result, alu_done, tx_busy,
    output alu_op, alu_a, alu_b, alu_start, tx_data, tx_start, busy, frame_err
  );
  modport slave (
    output rx_data, rx_valid, alu_result, alu_done, tx_busy,
    input  alu_op, alu_a, alu_b, alu_start, tx_data, tx_start, busy, frame_err
  );
endinterface

// File: rtl/alu_cmd_framer.sv
// alu_cmd_framer: gathers opcode/A/B bytes from the UART rx, launches the ALU, sends the result byte.
// Define ALU_FRAMER_OPCHECK_EN to reject opcode nibbles above 8 with a frame_err pulse.
module alu_cmd_framer #(
  parameter int TIMEOUT_CYCLES = 208320,
  parameter int CNT_W          = 18
) (
  input logic              clk,
  input logic              rst,
  alu_cmd_framer_if.master bus
);
  typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, WAIT_ALU, SEND} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       a_q, a_d, b_q, b_d, res_q, res_d, tx_data_q, tx_data_d;
  logic             alu_start_q, alu_start_d, tx_start_q, tx_start_d;
  logic             busy_q, busy_d, err_q, err_d;
  logic             op_ok, expired;
`ifdef ALU_FRAMER_OPCHECK_EN
  assign op_ok = bus.rx_data[3:0] <= 4'd8;
`else
  assign op_ok = 1'b1;
`endif
  assign expired = cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    tx_data_d   = tx_data_q;
    alu_start_d = 1'b0;
    tx_start_d  = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: if (bus.rx_valid) begin
        if (op_ok) begin
          op_d    = bus.rx_data[3:0];
          state_d = GET_A;
        end else err_d = 1'b1;
      end
      GET_A, GET_B: if (bus.rx_valid) begin
        a_d     = state_q == GET_A ? bus.rx_data : a_q;
        b_d     = state_q == GET_B ? bus.rx_data : b_q;
        state_d = state_q == GET_A ? GET_B : EXEC;
      end else if (expired) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else cnt_d = cnt_q + 1'b1;
      EXEC: begin
        alu_start_d = 1'b1;
        state_d     = WAIT_ALU;
      end
      WAIT_ALU: if (bus.alu_done) begin
        res_d   = bus.alu_result;
        state_d = SEND;
      end
      SEND: if (!bus.tx_busy) begin
        tx_data_d  = res_q;
        tx_start_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // bytes arriving mid-operation are dropped but reported
    if (bus.rx_valid && (state_q == EXEC || state_q == WAIT_ALU || state_q == SEND)) err_d = 1'b1;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      tx_data_q   <= '0;
      alu_start_q <= 1'b0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      tx_data_q   <= tx_data_d;
      alu_start_q <= alu_start_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end
  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_start = alu_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = err_q;
endmodule

// File: doc/alu_cmd_framer.md
# alu_cmd_framer

Command framer between the UART receiver and the ALU in the UART-ALU design. It collects the three-byte command frame (opcode, A, B) from the receiver's byte stream and issues one ALU operation. It captures the 8-bit result and hands it to the UART transmitter as a single byte. It also owns frame-level error handling: inter-byte timeout, bytes arriving while busy, and, optionally, illegal opcodes.

## Interface
- `TIMEOUT_CYCLES`, 208320: max idle cycles between bytes of one frame (4 byte-times at 9600 baud, 50 MHz clock).
- `CNT_W`, 18: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only when `rx_valid` is high.
- `rx_valid`  in  1  single-cycle strobe from the UART receiver.
- `alu_op`  out  4  opcode, taken from the low nibble of byte 0.
- `alu_a`  out  8  operand A.
- `alu_b`  out  8  operand B.
- `alu_start`  out  1  single-cycle ALU launch pulse.
- `alu_result`  in  8  ALU result; valid when `alu_done` is high.
- `alu_done`  in  1  ALU completion strobe.
- `tx_data`  out  8  byte to transmit; held until the next send.
- `tx_start`  out  1  single-cycle transmit request.
- `tx_busy`  in  1  transmitter busy.
- `busy`  out  1  high in any state other than IDLE.
- `frame_err`  out  1  single-cycle error pulse.

## Operation
- States: IDLE, GET_A, GET_B, EXEC, WAIT_ALU, SEND.
- IDLE: on `rx_valid`, register `alu_op <= rx_data[3:0]` and go to GET_A. `rx_data[7:4]` is ignored.
- GET_A: on `rx_valid`, register `alu_a` and go to GET_B.
- GET_B: on `rx_valid`, register `alu_b` and go to EXEC.
- EXEC: drive `alu_start` for exactly one cycle, then go to WAIT_ALU.
- WAIT_ALU: on `alu_done`, capture `alu_result` and go to SEND. There is no ALU timeout.
- SEND: when `tx_busy` is low, load `tx_data` with the captured result, pulse `tx_start` for one cycle, and return to IDLE. If `tx_busy` is high, wait in SEND.
- Timeout: the counter clears on every accepted byte and counts only in GET_A and GET_B. When it reaches `TIMEOUT_CYCLES`, the frame is discarded, `frame_err` pulses, the state returns to IDLE, and no ALU or TX activity occurs.
- Overrun: `rx_valid` in EXEC, WAIT_ALU or SEND drops the byte and pulses `frame_err`. The current operation continues unaffected.
- `rx_valid` and timeout expiring in the same cycle: the byte wins. It is accepted and the counter clears.
- `alu_op`, `alu_a`, `alu_b` hold their values after the frame until overwritten by the next frame.

## Timing
- All outputs are registered. Reset value of every output is 0.
- `rx_valid` of byte B in cycle N: `alu_start` is high in cycle N+2 (GET_B→EXEC at N+1, pulse registered out of EXEC).
- `alu_done` in cycle M with `tx_busy` low: `tx_start` and the new `tx_data` appear in cycle M+2.
- `alu_done` is honoured from the cycle after `alu_start` onward. A combinational ALU may tie `alu_done` to a one-cycle delay of `alu_start`.
- Reset asserted mid-frame aborts immediately. No `alu_start` or `tx_start` is emitted, and the state is IDLE after release.
- Back-to-back frames need no gap. The opcode byte is accepted in IDLE on the cycle after `tx_start`.

## Configuration
- `ALU_FRAMER_OPCHECK_EN` defined: an opcode nibble above 8 is illegal.
  - The opcode byte is discarded, `frame_err` pulses, and the state stays IDLE.
  - The following A and B bytes are treated as new opcode bytes.
- Not defined: all 16 opcode values are forwarded to the ALU unchanged.

## Test plan
- ADD frame 0x00, 25, 17 with an ALU model returning the sum → `alu_op`=0, `alu_a`=25, `alu_b`=17, exactly one `alu_start`, one `tx_start` with `tx_data`=0x2A, `frame_err` never set.
- Upper-nibble masking: 0xA3, 12, 5 with an OR model → `alu_op`=3, `tx_data`=0x0D.
- Timeout: 0x01, 60, then silence for `TIMEOUT_CYCLES`+10 cycles → one `frame_err` pulse, no `alu_start`. A following frame 0x01, 60, 20 yields `tx_data`=0x28.
- TX backpressure: hold `tx_busy` high for 1000 cycles after `alu_done` → `tx_start` fires 1 cycle after `tx_busy` falls. An extra `rx_valid` during the wait gives a `frame_err` pulse and the result is unchanged.
- Opcode 0x0F, 1, 2:
  - With `ALU_FRAMER_OPCHECK_EN` → `frame_err` pulses and no `alu_start` for that opcode byte.
  - Without the macro → `alu_op`=0xF and `alu_start` pulses.
- Reset (`rst`=0) asserted after byte A → all outputs 0, no `tx_start`. The next full frame completes normally.
